// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: RV32 control-flow opcodes,
// branch funct3 encodings and the resolve FSM state encoding.
package bru_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Branch condition decode: maps FUNCT3 and the comparator flags to a
// taken/illegal pair.
module branch_cond_decode
  import bru_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = br_eq_i;
      BNE:     taken_o = ~br_eq_i;
      BLT:     taken_o = br_lt_i;
      BGE:     taken_o = ~br_lt_i;
      BLTU:    taken_o = br_ltu_i;
      BGEU:    taken_o = ~br_ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver with registered results, redirect pulse
// and timed fetch flush. Define BRU_STATS_EN to enable the statistics counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  IMM_B,
  input  logic [XLEN-1:0]  IMM_J,
  input  logic [XLEN-1:0]  IMM_I,
  input  logic             BR_EQ,
  input  logic             BR_LT,
  input  logic             BR_LTU,
  output logic             OUT_VALID,
  output logic             TAKEN,
  output logic [XLEN-1:0]  TARGET,
  output logic [XLEN-1:0]  LINK,
  output logic             REDIRECT,
  output logic             FLUSH,
  output logic             ILLEGAL,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] STAT_BR_CNT,
  output logic [CNT_W-1:0] STAT_TAKEN_CNT
);

  // state   | meaning
  // S_RUN   | accepting instructions
  // S_FLUSH | squashing fetch/decode after a redirect, upstream stalled
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            accept;
  logic            is_br, is_jal, is_jalr;
  logic            cond_taken, cond_illegal;
  logic [XLEN-1:0] link_d, br_tgt, jal_tgt, jalr_sum, jalr_tgt;
  logic            taken_d, illegal_d, misalign_d, redirect_d;
  logic [XLEN-1:0] target_d;

  logic            out_valid_q, taken_q, redirect_q, illegal_q, misalign_q;
  logic [XLEN-1:0] target_q, link_q;

  branch_cond_decode u_cond (
    .funct3_i  (FUNCT3),
    .br_eq_i   (BR_EQ),
    .br_lt_i   (BR_LT),
    .br_ltu_i  (BR_LTU),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign IN_READY = (state_q == S_RUN);
  assign accept   = IN_VALID & IN_READY;
  assign is_br    = (OPCODE == OP_BRANCH);
  assign is_jal   = (OPCODE == OP_JAL);
  assign is_jalr  = (OPCODE == OP_JALR);

  assign link_d   = PC + XLEN'(4);
  assign br_tgt   = PC + IMM_B;
  assign jal_tgt  = PC + IMM_J;
  assign jalr_sum = RS1 + IMM_I;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    target_d  = link_d;
    if (is_br) begin
      taken_d   = cond_taken;
      illegal_d = cond_illegal;
      if (cond_taken) target_d = br_tgt;
    end else if (is_jal) begin
      taken_d  = 1'b1;
      target_d = jal_tgt;
    end else if (is_jalr) begin
      taken_d  = 1'b1;
      target_d = jalr_tgt;
    end
  end

  // A misaligned target traps elsewhere, so it neither redirects nor flushes.
  assign misalign_d = taken_d & target_d[1];
  assign redirect_d = taken_d & ~target_d[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (accept && redirect_d && (FLUSH_CYCLES != 0)) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      redirect_q  <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      misalign_q  <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= accept;
      redirect_q  <= accept & redirect_d;
      if (accept) begin
        taken_q    <= taken_d;
        illegal_q  <= illegal_d;
        misalign_q <= misalign_d;
        target_q   <= target_d;
        link_q     <= link_d;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign TAKEN     = taken_q;
  assign TARGET    = target_q;
  assign LINK      = link_q;
  assign REDIRECT  = redirect_q;
  assign FLUSH     = (state_q == S_FLUSH);
  assign ILLEGAL   = illegal_q;
  assign MISALIGN  = misalign_q;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q;
  logic             counted;

  assign counted = is_br | is_jal | is_jalr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (accept) begin
      if (counted && (br_cnt_q != {CNT_W{1'b1}}))
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (taken_d && (taken_cnt_q != {CNT_W{1'b1}}))
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign STAT_BR_CNT    = br_cnt_q;
  assign STAT_TAKEN_CNT = taken_cnt_q;
`else
  assign STAT_BR_CNT    = '0;
  assign STAT_TAKEN_CNT = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2, CNT_W=2).
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int CNT_W = 2;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JL = 7'b1101111,
                         OP_JR = 7'b1100111, OP_ALU = 7'b0110011;

  logic CLK, RST, IN_VALID, IN_READY;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic [XLEN-1:0] PC, RS1, IMM_B, IMM_J, IMM_I;
  logic BR_EQ, BR_LT, BR_LTU;
  logic OUT_VALID, TAKEN, REDIRECT, FLUSH, ILLEGAL, MISALIGN;
  logic [XLEN-1:0] TARGET, LINK;
  logic [CNT_W-1:0] STAT_BR_CNT, STAT_TAKEN_CNT;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .PC(PC), .RS1(RS1),
    .IMM_B(IMM_B), .IMM_J(IMM_J), .IMM_I(IMM_I),
    .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
    .OUT_VALID(OUT_VALID), .TAKEN(TAKEN), .TARGET(TARGET), .LINK(LINK),
    .REDIRECT(REDIRECT), .FLUSH(FLUSH), .ILLEGAL(ILLEGAL), .MISALIGN(MISALIGN),
    .STAT_BR_CNT(STAT_BR_CNT), .STAT_TAKEN_CNT(STAT_TAKEN_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] ib, input logic [31:0] ij,
                       input logic [31:0] ii, input logic eq, input logic lt,
                       input logic ltu);
    IN_VALID = 1'b1; OPCODE = op; FUNCT3 = f3; PC = pc; RS1 = rs1;
    IMM_B = ib; IMM_J = ij; IMM_I = ii; BR_EQ = eq; BR_LT = lt; BR_LTU = ltu;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0;
    drive(OP_ALU, 3'b000, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    #12;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", IN_READY); end
    checks++; if ({OUT_VALID, TAKEN, REDIRECT, FLUSH, ILLEGAL, MISALIGN} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b exp 000000", {OUT_VALID, TAKEN, REDIRECT, FLUSH, ILLEGAL, MISALIGN}); end
    checks++; if ({TARGET, LINK} !== 64'h0) begin errors++; $display("FAIL rst_target_link got %h/%h exp 0/0", TARGET, LINK); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_beq_taken();
    drive(OP_BR, 3'b000, 32'h100, '0, 32'h20, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    // Hold a different instruction valid during the flush; it must be ignored.
    drive(OP_JL, 3'b000, 32'h800, '0, '0, 32'h40, '0, 1'b0, 1'b0, 1'b0);
    checks++; if ({OUT_VALID, TAKEN, REDIRECT, MISALIGN} !== 4'b1110) begin errors++; $display("FAIL beq_flags got %b exp 1110", {OUT_VALID, TAKEN, REDIRECT, MISALIGN}); end
    checks++; if (TARGET !== 32'h120) begin errors++; $display("FAIL beq_target got %h exp 00000120", TARGET); end
    checks++; if (LINK !== 32'h104) begin errors++; $display("FAIL beq_link got %h exp 00000104", LINK); end
    checks++; if ({FLUSH, IN_READY} !== 2'b10) begin errors++; $display("FAIL beq_flush1 got %b exp 10", {FLUSH, IN_READY}); end
    step();
    IN_VALID = 1'b0;
    checks++; if ({OUT_VALID, REDIRECT, FLUSH, IN_READY} !== 4'b0010) begin errors++; $display("FAIL beq_flush2 got %b exp 0010", {OUT_VALID, REDIRECT, FLUSH, IN_READY}); end
    checks++; if (TARGET !== 32'h120) begin errors++; $display("FAIL beq_hold got %h exp 00000120", TARGET); end
    step();
    checks++; if ({FLUSH, IN_READY, OUT_VALID} !== 3'b010) begin errors++; $display("FAIL beq_end got %b exp 010", {FLUSH, IN_READY, OUT_VALID}); end
  endtask

  task automatic test_back_to_back();
    drive(OP_BR, 3'b111, 32'h200, '0, 32'h40, '0, '0, 1'b0, 1'b0, 1'b1);
    step();
    drive(OP_BR, 3'b001, 32'h300, '0, 32'h40, '0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if ({OUT_VALID, TAKEN, REDIRECT, FLUSH, IN_READY} !== 5'b10001) begin errors++; $display("FAIL bgeu_flags got %b exp 10001", {OUT_VALID, TAKEN, REDIRECT, FLUSH, IN_READY}); end
    checks++; if (TARGET !== 32'h204) begin errors++; $display("FAIL bgeu_target got %h exp 00000204", TARGET); end
    step();
    IN_VALID = 1'b0;
    checks++; if ({OUT_VALID, TAKEN, REDIRECT, FLUSH, IN_READY} !== 5'b10001) begin errors++; $display("FAIL bne_flags got %b exp 10001", {OUT_VALID, TAKEN, REDIRECT, FLUSH, IN_READY}); end
    checks++; if (TARGET !== 32'h304) begin errors++; $display("FAIL bne_target got %h exp 00000304", TARGET); end
    step();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_blt_negative();
    drive(OP_BR, 3'b100, 32'h1000, '0, 32'hFFFF_FFF0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    IN_VALID = 1'b0;
    checks++; if ({TAKEN, REDIRECT, FLUSH} !== 3'b111) begin errors++; $display("FAIL blt_flags got %b exp 111", {TAKEN, REDIRECT, FLUSH}); end
    checks++; if (TARGET !== 32'h0FF0) begin errors++; $display("FAIL blt_target got %h exp 00000ff0", TARGET); end
    step(); step();
  endtask

  task automatic test_jalr_misalign();
    drive(OP_JR, 3'b000, 32'h50, 32'h1003, '0, '0, 32'h4, 1'b0, 1'b0, 1'b0);
    step();
    drive(OP_JR, 3'b000, 32'h60, 32'h1001, '0, '0, 32'h4, 1'b0, 1'b0, 1'b0);
    checks++; if ({TAKEN, MISALIGN, REDIRECT, FLUSH, IN_READY} !== 5'b11001) begin errors++; $display("FAIL jalr_mis_flags got %b exp 11001", {TAKEN, MISALIGN, REDIRECT, FLUSH, IN_READY}); end
    checks++; if (TARGET !== 32'h1006) begin errors++; $display("FAIL jalr_mis_target got %h exp 00001006", TARGET); end
    step();
    IN_VALID = 1'b0;
    checks++; if ({TAKEN, MISALIGN, REDIRECT, FLUSH} !== 4'b1011) begin errors++; $display("FAIL jalr_ok_flags got %b exp 1011", {TAKEN, MISALIGN, REDIRECT, FLUSH}); end
    checks++; if (TARGET !== 32'h1004) begin errors++; $display("FAIL jalr_ok_target got %h exp 00001004", TARGET); end
    checks++; if (LINK !== 32'h64) begin errors++; $display("FAIL jalr_link got %h exp 00000064", LINK); end
    step(); step();
  endtask

  task automatic test_illegal_other();
    drive(OP_BR, 3'b010, 32'h400, '0, 32'h80, '0, '0, 1'b1, 1'b1, 1'b1);
    step();
    drive(OP_ALU, 3'b000, 32'h500, '0, 32'h80, 32'h80, 32'h80, 1'b1, 1'b1, 1'b1);
    checks++; if ({OUT_VALID, ILLEGAL, TAKEN, REDIRECT, FLUSH} !== 5'b11000) begin errors++; $display("FAIL illegal_flags got %b exp 11000", {OUT_VALID, ILLEGAL, TAKEN, REDIRECT, FLUSH}); end
    checks++; if (TARGET !== 32'h404) begin errors++; $display("FAIL illegal_target got %h exp 00000404", TARGET); end
    step();
    IN_VALID = 1'b0;
    checks++; if ({OUT_VALID, ILLEGAL, TAKEN, REDIRECT} !== 4'b1000) begin errors++; $display("FAIL other_flags got %b exp 1000", {OUT_VALID, ILLEGAL, TAKEN, REDIRECT}); end
    checks++; if (TARGET !== 32'h504) begin errors++; $display("FAIL other_target got %h exp 00000504", TARGET); end
    step();
  endtask

  task automatic test_jal_wrap();
    drive(OP_JL, 3'b000, 32'hFFFF_FFF0, '0, '0, 32'h20, '0, 1'b0, 1'b0, 1'b0);
    step();
    IN_VALID = 1'b0;
    checks++; if (TARGET !== 32'h10) begin errors++; $display("FAIL jal_wrap_target got %h exp 00000010", TARGET); end
    checks++; if (LINK !== 32'hFFFF_FFF4) begin errors++; $display("FAIL jal_wrap_link got %h exp fffffff4", LINK); end
    checks++; if ({TAKEN, REDIRECT, FLUSH} !== 3'b111) begin errors++; $display("FAIL jal_wrap_flags got %b exp 111", {TAKEN, REDIRECT, FLUSH}); end
    step(); step();
  endtask

  task automatic test_reset_mid_flush();
    drive(OP_JL, 3'b000, 32'h0, '0, '0, 32'h40, '0, 1'b0, 1'b0, 1'b0);
    step();
    IN_VALID = 1'b0;
    checks++; if (FLUSH !== 1'b1) begin errors++; $display("FAIL rmf_pre_flush got %b exp 1", FLUSH); end
    RST = 1'b1;
    #1;
    checks++; if ({FLUSH, IN_READY} !== 2'b01) begin errors++; $display("FAIL rmf_ready got %b exp 01", {FLUSH, IN_READY}); end
    checks++; if ({OUT_VALID, TAKEN, REDIRECT, ILLEGAL, MISALIGN, TARGET, LINK} !== 69'h0) begin errors++; $display("FAIL rmf_outputs got %b%b%b%b%b %h %h exp all zero", OUT_VALID, TAKEN, REDIRECT, ILLEGAL, MISALIGN, TARGET, LINK); end
    #2;
    RST = 1'b0;
    step();
    checks++; if ({FLUSH, IN_READY} !== 2'b01) begin errors++; $display("FAIL rmf_post got %b exp 01", {FLUSH, IN_READY}); end
  endtask

  task automatic test_stats();
`ifdef BRU_STATS_EN
    for (int n = 1; n <= 5; n++) begin
      drive(OP_JL, 3'b000, 32'h100, '0, '0, 32'h40, '0, 1'b0, 1'b0, 1'b0);
      step();
      IN_VALID = 1'b0;
      checks++; if (STAT_BR_CNT !== CNT_W'((n > 3) ? 3 : n)) begin errors++; $display("FAIL stat_br_%0d got %0d exp %0d", n, STAT_BR_CNT, (n > 3) ? 3 : n); end
      checks++; if (STAT_TAKEN_CNT !== CNT_W'((n > 3) ? 3 : n)) begin errors++; $display("FAIL stat_taken_%0d got %0d exp %0d", n, STAT_TAKEN_CNT, (n > 3) ? 3 : n); end
      step(); step();
    end
`else
    drive(OP_JL, 3'b000, 32'h100, '0, '0, 32'h40, '0, 1'b0, 1'b0, 1'b0);
    step();
    IN_VALID = 1'b0;
    checks++; if ({STAT_BR_CNT, STAT_TAKEN_CNT} !== '0) begin errors++; $display("FAIL stat_off got %0d/%0d exp 0/0", STAT_BR_CNT, STAT_TAKEN_CNT); end
    step(); step();
`endif
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_back_to_back();
    test_blt_negative();
    test_jalr_misalign();
    test_illegal_other();
    test_jal_wrap();
    test_reset_mid_flush();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage consumer of the branch condition generator flags (BR_EQ/BR_LT/BR_LTU) in the OTTER core. It takes one control-flow instruction per accepted handshake and decodes the branch condition from OPCODE/FUNCT3. It computes the target and registers the decision. On a taken transfer it issues a one-cycle redirect and then holds a fetch/decode flush for a programmable number of cycles, back-pressuring upstream meanwhile.

Parameters:
XLEN, 32, datapath width of PC, immediates, RS1 and targets
FLUSH_CYCLES, 2, cycles FLUSH is held after a redirect; legal range 0..7
CNT_W, 32, width of the statistics counters (optional feature only)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
IN_VALID  input  1  upstream instruction valid
IN_READY  output  1  block can accept; 1 only in RUN state
OPCODE  input  7  instruction opcode
FUNCT3  input  3  branch type
PC  input  XLEN  PC of the instruction
RS1  input  XLEN  rs1 value, used by JALR
IMM_B  input  XLEN  sign-extended B-immediate
IMM_J  input  XLEN  sign-extended J-immediate
IMM_I  input  XLEN  sign-extended I-immediate
BR_EQ  input  1  RS1==RS2
BR_LT  input  1  signed RS1<RS2
BR_LTU  input  1  unsigned RS1<RS2
OUT_VALID  output  1  registered result valid, one-cycle pulse per accepted instruction
TAKEN  output  1  control transfer taken
TARGET  output  XLEN  taken target, or PC+4 if not taken
LINK  output  XLEN  PC+4, the JAL/JALR writeback value
REDIRECT  output  1  one-cycle pulse: fetch loads TARGET
FLUSH  output  1  squash younger instructions
ILLEGAL  output  1  BRANCH opcode with FUNCT3 010/011
MISALIGN  output  1  taken target has bit 1 set
STAT_BR_CNT  output  CNT_W  control-flow instructions resolved
STAT_TAKEN_CNT  output  CNT_W  taken transfers

Behaviour:
- Reset (async, any state): FSM=RUN, flush counter=0. All outputs 0 except IN_READY=1.
- Accept: IN_VALID & IN_READY on a rising edge. Results are registered, so OUT_VALID/TAKEN/TARGET/LINK/ILLEGAL/MISALIGN/REDIRECT appear the next cycle. Latency is 1.
- Outputs other than the pulses hold their last value until the next accept.
- Decode when OPCODE=1100011 (BRANCH):
  - FUNCT3 000 → BR_EQ; 001 → !BR_EQ
  - 100 → BR_LT; 101 → !BR_LT
  - 110 → BR_LTU; 111 → !BR_LTU
  - 010/011 → TAKEN=0, ILLEGAL=1
  - Target PC+IMM_B.
- JAL (1101111): always taken, target PC+IMM_J.
- JALR (1100111): always taken, target (RS1+IMM_I) with bit 0 cleared.
- Any other opcode: OUT_VALID=1, TAKEN=0, TARGET=PC+4, not counted in stats.
- All adds are XLEN-bit modulo; wrap-around is silent.
- MISALIGN=1 when TAKEN and target bit1=1. In that case REDIRECT=0 and no flush (the trap is handled elsewhere), but TAKEN and TARGET are still reported.
- FSM states RUN and FLUSH:
  - RUN → FLUSH on accepting an instruction that produces REDIRECT, provided FLUSH_CYCLES>0. The counter loads FLUSH_CYCLES.
  - In FLUSH: FLUSH=1, IN_READY=0, IN_VALID ignored, counter decrements each cycle, return to RUN when it reaches 1→0.
  - FLUSH asserts in the same cycle as REDIRECT, so it is high for exactly FLUSH_CYCLES cycles.
  - FLUSH_CYCLES=0: REDIRECT pulses, FLUSH never asserts, IN_READY stays 1, back-to-back accepts are allowed.
- Not-taken branches never leave RUN, so back-to-back accepts at full throughput are allowed.
- RST asserted mid-FLUSH aborts the flush immediately; the first post-reset cycle has IN_READY=1.

Optional Feature:
BRU_STATS_EN
- Defined: STAT_BR_CNT increments per accepted BRANCH/JAL/JALR, ILLEGAL included. STAT_TAKEN_CNT increments per TAKEN result.
- Counters saturate at all-ones, reset to 0, and update on the same edge the result registers.
- Undefined: both ports driven constant 0, no counter flops.

Decomposition:
- Shared package bru_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - funct3 enum BEQ/BNE/BLT/BGE/BLTU/BGEU
  - FSM state enum {RUN, FLUSH}
- One natural sub-module: branch_cond_decode, combinational FUNCT3 + flags → taken/illegal.
- FSM, target adders and registers stay in the top.

Test Plan:
- BEQ, PC=0x100, IMM_B=0x20, BR_EQ=1 → next cycle OUT_VALID=1, TAKEN=1, TARGET=0x120, REDIRECT=1. FLUSH high 2 cycles, IN_READY low 2 cycles.
- BGEU with BR_LTU=1, then BNE with BR_EQ=1 on consecutive cycles → two OUT_VALID pulses, TAKEN=0, TARGET=PC+4, no FLUSH.
- JALR, RS1=0x1003, IMM_I=0x4 → TARGET=0x1006, MISALIGN=1, REDIRECT=0, FLUSH=0. Same with RS1=0x1001 → TARGET=0x1004, REDIRECT=1.
- BRANCH with FUNCT3=010 → ILLEGAL=1, TAKEN=0. JAL with PC=0xFFFFFFF0, IMM_J=0x20 → TARGET=0x10, LINK=0xFFFFFFF4.
- Taken JAL, then RST pulsed during the 1st FLUSH cycle → FLUSH=0 and IN_READY=1 immediately, all outputs 0.
- With BRU_STATS_EN and CNT_W=2: 5 taken JALs → both counters saturate at 3.
